// File: rtl/filt_pkg.sv
// Shared constants for the edge-deglitch filter bank: tick width, channel-id width,
// default prescale and filter time, plus the zero-filter-time guard.
package filt_pkg;
  localparam int TICK_W = 8;
  localparam int CHID_W = 3;
  localparam int PRESCALE_DEF = 30;
  localparam logic [TICK_W-1:0] FILTER_TIME_DEF = 8'd200;

  // A filter time of zero would make the deadline equal the capture timer; treat it as one tick.
  function automatic logic [TICK_W-1:0] eff_ft(input logic [TICK_W-1:0] ft);
    return (ft == '0) ? TICK_W'(1) : ft;
  endfunction
endpackage

// File: rtl/filter_timebase.sv
// Shared timebase: prescaler, free-running tick counter and the filter-time shadow register.
// Handshake: cfg_wr_i is a one-clk pulse that loads the shadow; cfg_ack_o pulses (together with tick_o) when the shadow becomes active.
module filter_timebase
  import filt_pkg::*;
#(
  parameter int                PRESCALE    = PRESCALE_DEF,
  parameter logic [TICK_W-1:0] FILTER_TIME = FILTER_TIME_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              cfg_wr_i,
  input  logic [TICK_W-1:0] cfg_time_i,
  output logic [TICK_W-1:0] timer_o,
  output logic              tick_o,
  output logic [TICK_W-1:0] ft_o,
  output logic              cfg_ack_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]     pre_q, pre_d;
  logic [TICK_W-1:0] timer_q, timer_d;
  logic              tick_q, tick_d;
  logic [TICK_W-1:0] ft_q, ft_d;
  logic [TICK_W-1:0] sh_q, sh_d;
  logic              shv_q, shv_d;
  logic              ack_q, ack_d;

  always_comb begin
    pre_d   = pre_q;
    timer_d = timer_q;
    tick_d  = 1'b0;
    ft_d    = ft_q;
    sh_d    = sh_q;
    shv_d   = shv_q;
    ack_d   = 1'b0;
    if (cfg_wr_i) begin
      sh_d  = cfg_time_i;
      shv_d = 1'b1;
    end
    if (en_i) begin
      if (pre_q == PRE_LAST) begin
        pre_d   = '0;
        timer_d = timer_q + TICK_W'(1);
        tick_d  = 1'b1;
        // A write landing on the tick edge stays pending for the following tick.
        if (shv_q) begin
          ft_d  = sh_q;
          ack_d = 1'b1;
          shv_d = cfg_wr_i;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      timer_q <= '0;
      tick_q  <= 1'b0;
      ft_q    <= FILTER_TIME;
      sh_q    <= '0;
      shv_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      timer_q <= timer_d;
      tick_q  <= tick_d;
      ft_q    <= ft_d;
      sh_q    <= sh_d;
      shv_q   <= shv_d;
      ack_q   <= ack_d;
    end
  end

  assign timer_o   = timer_q;
  assign tick_o    = tick_q;
  assign ft_o      = ft_q;
  assign cfg_ack_o = ack_q;
endmodule

// File: rtl/filter_bank_sched.sv
// Multi-channel edge deglitcher: per-channel synchronise/capture every clk, one shared
// deadline comparator visited round-robin, registered change strobe with channel id.
module filter_bank_sched
  import filt_pkg::*;
#(
  parameter int                NCH         = 4,
  parameter int                PRESCALE    = PRESCALE_DEF,
  parameter logic [TICK_W-1:0] FILTER_TIME = FILTER_TIME_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    sin,
  input  logic              cfg_wr,
  input  logic [TICK_W-1:0] cfg_time,
  output logic              cfg_ack,
  output logic [TICK_W-1:0] timer,
  output logic              tick,
  output logic [NCH-1:0]    sout,
  output logic              chg_stb,
  output logic [CHID_W-1:0] chg_id
);
  logic [TICK_W-1:0] ft;
  logic [TICK_W-1:0] ft_eff;

  filter_timebase #(
    .PRESCALE    (PRESCALE),
    .FILTER_TIME (FILTER_TIME)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .cfg_wr_i   (cfg_wr),
    .cfg_time_i (cfg_time),
    .timer_o    (timer),
    .tick_o     (tick),
    .ft_o       (ft),
    .cfg_ack_o  (cfg_ack)
  );

  logic [NCH-1:0]             meta_q, sync_q, prev_q;
  logic [NCH-1:0]             edg;
  logic [NCH-1:0]             lvl_q, lvl_d;
  logic [NCH-1:0]             pend_q, pend_d;
  logic [NCH-1:0][TICK_W-1:0] dl_q, dl_d;
  logic [NCH-1:0]             sout_q, sout_d;
  logic [NCH-1:0]             hit;
  logic [CHID_W-1:0]          slot_q, slot_d;
  logic                       stb_q, stb_d;
  logic [CHID_W-1:0]          id_q, id_d;

  assign edg    = sync_q ^ prev_q;
  assign ft_eff = eff_ft(ft);

  // The single comparator: only the channel under the slot pointer can hit its deadline.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit[i] = en && (slot_q == CHID_W'(i)) && pend_q[i] && (dl_q[i] == timer) && !edg[i];
    end
  end

  always_comb begin
    lvl_d  = lvl_q;
    pend_d = pend_q;
    dl_d   = dl_q;
    sout_d = sout_q;
    stb_d  = 1'b0;
    id_d   = id_q;
    slot_d = (slot_q == CHID_W'(NCH - 1)) ? '0 : slot_q + CHID_W'(1);
    if (!en) begin
      pend_d = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (edg[i]) begin
          lvl_d[i]  = sync_q[i];
          dl_d[i]   = timer + ft_eff;
          pend_d[i] = 1'b1;
        end else if (hit[i]) begin
          pend_d[i] = 1'b0;
          sout_d[i] = lvl_q[i];
          if (lvl_q[i] != sout_q[i]) begin
            stb_d = 1'b1;
            id_d  = CHID_W'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      lvl_q  <= '0;
      pend_q <= '0;
      dl_q   <= '0;
      sout_q <= '0;
      slot_q <= '0;
      stb_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      meta_q <= sin;
      sync_q <= meta_q;
      prev_q <= sync_q;
      lvl_q  <= lvl_d;
      pend_q <= pend_d;
      dl_q   <= dl_d;
      sout_q <= sout_d;
      slot_q <= slot_d;
      stb_q  <= stb_d;
      id_q   <= id_d;
    end
  end

  assign sout    = sout_q;
  assign chg_stb = stb_q;
  assign chg_id  = id_q;
endmodule
